// File: rtl/pwm_monitor_pkg.sv
`timescale 1ns/1ps
// Shared definitions for pwm_monitor: FSM state encoding, counter width default and mode width.
package pwm_monitor_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int MODE_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_monitor_edge_detect.sv
`timescale 1ns/1ps
// pwm_edge_detect: two-stage sampler of the pwm waveform (pwm_q, pwm_qq) and
// registered one-cycle rise/fall strobes derived from the two stages.
module pwm_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic rise,
  output logic fall
);

  logic pwm_q, pwm_d;
  logic pwm_qq, pwm_qq_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // The strobes are registered so the FSM acts on the edge exactly one
  // cycle after pwm_qq takes the new level.
  always_comb begin
    pwm_d    = pwm;
    pwm_qq_d = pwm_q;
    rise_d   = pwm_q & ~pwm_qq;
    fall_d   = ~pwm_q & pwm_qq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q  <= 1'b0;
      pwm_qq <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      pwm_qq <= pwm_qq_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_monitor.sv
`timescale 1ns/1ps
// pwm_monitor: measures high-phase and rising-to-rising period of pwm in clk cycles,
// tagged with the generator mode. Define PWM_MONITOR_TIMEOUT_EN to report edge-less waveforms.
module pwm_monitor
  import pwm_monitor_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm,
  input  logic [MODE_W-1:0] mode,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [MODE_W-1:0] meas_mode,
  output logic              sat,
  output logic              overrun,
  output logic              stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic rise, fall;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    hi_cap_q, hi_cap_d;
  logic [MODE_W-1:0]   cur_mode_q, cur_mode_d;
  logic                sat_int_q, sat_int_d;

  logic                meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]    high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
  logic [MODE_W-1:0]   meas_mode_q, meas_mode_d;
  logic                sat_q, sat_d;
  logic                overrun_q, overrun_d;
  logic                stuck_q, stuck_d;

  logic                pub;
  logic [CNT_W-1:0]    pub_high, pub_period;
  logic                pub_sat, pub_stuck;
  logic                cnt_at_max;
  logic [CNT_W-1:0]    cnt_inc;
  logic                mode_changed;
  logic                timeout_hit;
  logic                accept;

  pwm_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .pwm  (pwm),
    .rise (rise),
    .fall (fall)
  );

  assign cnt_at_max   = (cnt_q == CNT_MAX);
  assign cnt_inc      = cnt_at_max ? cnt_q : cnt_q + CNT_ONE;
  assign mode_changed = (mode != cur_mode_q);
  assign accept       = meas_valid_q & meas_ready;

`ifdef PWM_MONITOR_TIMEOUT_EN
  // Compared at full width so a TIMEOUT beyond the counter range never fires.
  assign timeout_hit = (32'(cnt_q) == TIMEOUT);
`else
  assign timeout_hit = 1'b0;
`endif

  // Measurement FSM: produces at most one publish request per cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_cap_d   = hi_cap_q;
    cur_mode_d = cur_mode_q;
    sat_int_d  = sat_int_q;
    pub        = 1'b0;
    pub_high   = hi_cap_q;
    pub_period = cnt_q;
    pub_sat    = sat_int_q;
    pub_stuck  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d      = CNT_ONE;
          cur_mode_d = mode;
          sat_int_d  = 1'b0;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (mode_changed) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          hi_cap_d  = cnt_q;
          cnt_d     = cnt_inc;
          sat_int_d = sat_int_q | cnt_at_max;
          state_d   = ST_LOW;
        end else if (timeout_hit) begin
          pub        = 1'b1;
          pub_high   = TIMEOUT_CNT;
          pub_period = TIMEOUT_CNT;
          pub_stuck  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d     = cnt_inc;
          sat_int_d = sat_int_q | cnt_at_max;
        end
      end
      ST_LOW: begin
        if (mode_changed) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          pub        = 1'b1;
          cnt_d      = CNT_ONE;
          cur_mode_d = mode;
          sat_int_d  = 1'b0;
          state_d    = ST_HIGH;
        end else if (timeout_hit) begin
          pub        = 1'b1;
          pub_period = TIMEOUT_CNT;
          pub_stuck  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d     = cnt_inc;
          sat_int_d = sat_int_q | cnt_at_max;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result holding register: a publish lands only if the slot is empty or
  // being emptied this cycle; otherwise it is dropped and flagged.
  always_comb begin
    meas_valid_d = meas_valid_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_mode_d  = meas_mode_q;
    sat_d        = sat_q;
    stuck_d      = stuck_q;
    overrun_d    = overrun_q;
    if (accept) begin
      meas_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (pub) begin
      if (!meas_valid_q || meas_ready) begin
        meas_valid_d = 1'b1;
        high_cnt_d   = pub_high;
        period_cnt_d = pub_period;
        meas_mode_d  = cur_mode_q;
        sat_d        = pub_sat;
        stuck_d      = pub_stuck;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_cap_q     <= '0;
      cur_mode_q   <= '0;
      sat_int_q    <= 1'b0;
      meas_valid_q <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_mode_q  <= '0;
      sat_q        <= 1'b0;
      overrun_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_cap_q     <= hi_cap_d;
      cur_mode_q   <= cur_mode_d;
      sat_int_q    <= sat_int_d;
      meas_valid_q <= meas_valid_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_mode_q  <= meas_mode_d;
      sat_q        <= sat_d;
      overrun_q    <= overrun_d;
      stuck_q      <= stuck_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_mode  = meas_mode_q;
  assign sat        = sat_q;
  assign overrun    = overrun_q;
  assign stuck      = stuck_q;

endmodule
